// File: rtl/collision_matrix.sv
// Pairwise collision detector between N_A group-A and N_B group-B drawing requests.
// It produces once-per-frame hit pulses (immediate or frame-deferred), a lowest-index pair report and a saturating hit count.
module collision_matrix #(
    parameter int N_A   = 4,
    parameter int N_B   = 8,
    parameter int MODE  = 0,
    parameter int CNT_W = 4
) (
    input  logic                                       clk,
    input  logic                                       resetN,
    input  logic                                       startOfFrame,
    input  logic                                       enable,
    input  logic [N_A-1:0]                             aDrawingRequest,
    input  logic [N_B-1:0]                             bDrawingRequest,
    output logic [N_A-1:0]                             SingleHitPulse_a,
    output logic [N_B-1:0]                             SingleHitPulse_b,
    output logic                                       hit_pair_valid,
    output logic [((N_A > 1) ? $clog2(N_A) : 1)-1:0]   hit_a_idx,
    output logic [((N_B > 1) ? $clog2(N_B) : 1)-1:0]   hit_b_idx,
    output logic [CNT_W-1:0]                           frame_hit_count
);

    localparam int IA_W  = (N_A > 1) ? $clog2(N_A) : 1;
    localparam int IB_W  = (N_B > 1) ? $clog2(N_B) : 1;
    localparam int SUM_W = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [IA_W-1:0] lowest_a(input logic [N_A-1:0] v);
        lowest_a = {IA_W{1'b0}};
        for (int i = N_A - 1; i >= 0; i--) begin
            if (v[i]) lowest_a = i[IA_W-1:0];
        end
    endfunction

    function automatic logic [IB_W-1:0] lowest_b(input logic [N_B-1:0] v);
        lowest_b = {IB_W{1'b0}};
        for (int j = N_B - 1; j >= 0; j--) begin
            if (v[j]) lowest_b = j[IB_W-1:0];
        end
    endfunction

    function automatic logic [4:0] popcnt_a(input logic [N_A-1:0] v);
        popcnt_a = 5'd0;
        for (int i = 0; i < N_A; i++) begin
            popcnt_a = popcnt_a + {4'd0, v[i]};
        end
    endfunction

    logic [N_A-1:0]   flags_a_q, flags_a_d, flags_a_eff_s, hit_a_s, new_a_s;
    logic [N_B-1:0]   flags_b_q, flags_b_d, flags_b_eff_s, hit_b_s, new_b_s;
    logic [CNT_W-1:0] run_q, run_d, frame_cnt_q, frame_cnt_d, run_base_s;
    logic [SUM_W-1:0] run_sum_s;
    logic [IA_W-1:0]  pi_s, ia_q, ia_d, pair_a_q, pair_a_d;
    logic [IB_W-1:0]  pj_s, ib_q, ib_d, pair_b_q, pair_b_d;
    logic [N_A-1:0]   pulse_a_q, pulse_a_d;
    logic [N_B-1:0]   pulse_b_q, pulse_b_d;
    logic             valid_q, valid_d, pair_vld_q, pair_vld_d;

    // Overlap detection, per-frame flags and saturating running count.
    always_comb begin
        // Row/column OR of the overlap matrix reduces to a channel AND the other group's OR.
        hit_a_s       = aDrawingRequest & {N_A{enable & (|bDrawingRequest)}};
        hit_b_s       = bDrawingRequest & {N_B{enable & (|aDrawingRequest)}};
        flags_a_eff_s = startOfFrame ? {N_A{1'b0}} : flags_a_q;
        flags_b_eff_s = startOfFrame ? {N_B{1'b0}} : flags_b_q;
        new_a_s       = hit_a_s & ~flags_a_eff_s;
        new_b_s       = hit_b_s & ~flags_b_eff_s;
        flags_a_d     = flags_a_eff_s | hit_a_s;
        flags_b_d     = flags_b_eff_s | hit_b_s;
        pi_s          = lowest_a(new_a_s);
        // Once pi is in newA its request is high, so its lowest overlap is the lowest B request.
        pj_s          = lowest_b(bDrawingRequest);
        run_base_s    = startOfFrame ? {CNT_W{1'b0}} : run_q;
        run_sum_s     = {5'd0, run_base_s} + {{CNT_W{1'b0}}, popcnt_a(new_a_s)};
        if (run_sum_s > {5'd0, CNT_MAX}) begin
            run_d = CNT_MAX;
        end else begin
            run_d = run_sum_s[CNT_W-1:0];
        end
        frame_cnt_d = startOfFrame ? run_q : frame_cnt_q;
    end

    // Pulse and pair-report selection for the configured mode.
    always_comb begin
        pulse_a_d  = {N_A{1'b0}};
        pulse_b_d  = {N_B{1'b0}};
        valid_d    = 1'b0;
        ia_d       = ia_q;
        ib_d       = ib_q;
        pair_vld_d = pair_vld_q;
        pair_a_d   = pair_a_q;
        pair_b_d   = pair_b_q;
        if (MODE == 0) begin
            pulse_a_d = new_a_s;
            pulse_b_d = new_b_s;
            valid_d   = |new_a_s;
            if (|new_a_s) begin
                ia_d = pi_s;
                ib_d = pj_s;
            end else begin
                ia_d = ia_q;
                ib_d = ib_q;
            end
        end else begin
            if (startOfFrame) begin
                pulse_a_d = flags_a_q;
                pulse_b_d = flags_b_q;
                valid_d   = pair_vld_q;
                if (pair_vld_q) begin
                    ia_d = pair_a_q;
                    ib_d = pair_b_q;
                end else begin
                    ia_d = ia_q;
                    ib_d = ib_q;
                end
            end else begin
                pulse_a_d = {N_A{1'b0}};
                pulse_b_d = {N_B{1'b0}};
                valid_d   = 1'b0;
            end
            // The first new A hit of a frame (including the boundary cycle) becomes the stored pair.
            if ((|new_a_s) && (startOfFrame || !pair_vld_q)) begin
                pair_vld_d = 1'b1;
                pair_a_d   = pi_s;
                pair_b_d   = pj_s;
            end else if (startOfFrame) begin
                pair_vld_d = 1'b0;
            end else begin
                pair_vld_d = pair_vld_q;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flags_a_q   <= {N_A{1'b0}};
            flags_b_q   <= {N_B{1'b0}};
            run_q       <= {CNT_W{1'b0}};
            frame_cnt_q <= {CNT_W{1'b0}};
            pulse_a_q   <= {N_A{1'b0}};
            pulse_b_q   <= {N_B{1'b0}};
            valid_q     <= 1'b0;
            ia_q        <= {IA_W{1'b0}};
            ib_q        <= {IB_W{1'b0}};
            pair_vld_q  <= 1'b0;
            pair_a_q    <= {IA_W{1'b0}};
            pair_b_q    <= {IB_W{1'b0}};
        end else begin
            flags_a_q   <= flags_a_d;
            flags_b_q   <= flags_b_d;
            run_q       <= run_d;
            frame_cnt_q <= frame_cnt_d;
            pulse_a_q   <= pulse_a_d;
            pulse_b_q   <= pulse_b_d;
            valid_q     <= valid_d;
            ia_q        <= ia_d;
            ib_q        <= ib_d;
            pair_vld_q  <= pair_vld_d;
            pair_a_q    <= pair_a_d;
            pair_b_q    <= pair_b_d;
        end
    end

    assign SingleHitPulse_a = pulse_a_q;
    assign SingleHitPulse_b = pulse_b_q;
    assign hit_pair_valid   = valid_q;
    assign hit_a_idx        = ia_q;
    assign hit_b_idx        = ib_q;
    assign frame_hit_count  = frame_cnt_q;

endmodule

// File: tb/tb_collision_matrix.sv
// Bench for collision_matrix: three instances (immediate, deferred, narrow counter) share stimulus.
// A frame-level model is checked against them every cycle, and directed literals pin that model.
module tb_collision_matrix;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] aReq = 4'd0;
    logic [7:0] bReq = 8'd0;

    logic [3:0] pa [3];
    logic [7:0] pb [3];
    logic       pv [3];
    logic [1:0] ia [3];
    logic [2:0] ib [3];
    logic [3:0] cnt [3];
    logic [1:0] cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    collision_matrix #(.N_A(4), .N_B(8), .MODE(0), .CNT_W(4)) u0 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .aDrawingRequest(aReq), .bDrawingRequest(bReq),
        .SingleHitPulse_a(pa[0]), .SingleHitPulse_b(pb[0]), .hit_pair_valid(pv[0]),
        .hit_a_idx(ia[0]), .hit_b_idx(ib[0]), .frame_hit_count(cnt[0]));

    collision_matrix #(.N_A(4), .N_B(8), .MODE(1), .CNT_W(4)) u1 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .aDrawingRequest(aReq), .bDrawingRequest(bReq),
        .SingleHitPulse_a(pa[1]), .SingleHitPulse_b(pb[1]), .hit_pair_valid(pv[1]),
        .hit_a_idx(ia[1]), .hit_b_idx(ib[1]), .frame_hit_count(cnt[1]));

    collision_matrix #(.N_A(4), .N_B(8), .MODE(0), .CNT_W(2)) u2 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .aDrawingRequest(aReq), .bDrawingRequest(bReq),
        .SingleHitPulse_a(pa[2]), .SingleHitPulse_b(pb[2]), .hit_pair_valid(pv[2]),
        .hit_a_idx(ia[2]), .hit_b_idx(ib[2]), .frame_hit_count(cnt2));

    assign cnt[2] = {2'b00, cnt2};

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Frame-level model state: channels hit this frame, first pair of the frame, expected outputs.
    logic [3:0] fa [3];
    logic [7:0] fb [3];
    int         fpa [3];
    int         fpb [3];
    logic [3:0] e_pa [3];
    logic [7:0] e_pb [3];
    logic       e_v [3];
    int         e_ia [3];
    int         e_ib [3];
    int         e_cnt [3];

    always @(posedge clk) begin : model
        logic [3:0] ha, na, pva;
        logic [7:0] hb, nb, pvb;
        int pi, pj, mode, maxc;
        for (int k = 0; k < 3; k++) begin
            mode = (k == 1) ? 1 : 0;
            maxc = (k == 2) ? 3 : 15;
            if (!resetN) begin
                fa[k] = 4'd0; fb[k] = 8'd0; fpa[k] = 0; fpb[k] = 0;
                e_pa[k] = 4'd0; e_pb[k] = 8'd0; e_v[k] = 1'b0;
                e_ia[k] = 0; e_ib[k] = 0; e_cnt[k] = 0;
            end else begin
                ha = 4'd0; hb = 8'd0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 8; j++)
                        if (enable && aReq[i] && bReq[j]) begin
                            ha[i] = 1'b1;
                            hb[j] = 1'b1;
                        end
                pva = startOfFrame ? 4'd0 : fa[k];
                pvb = startOfFrame ? 8'd0 : fb[k];
                na = ha & ~pva;
                nb = hb & ~pvb;
                pi = -1; pj = -1;
                for (int i = 3; i >= 0; i--) if (na[i]) pi = i;
                if (pi >= 0)
                    for (int j = 7; j >= 0; j--) if (aReq[pi] && bReq[j]) pj = j;
                if (startOfFrame)
                    e_cnt[k] = ($countones(fa[k]) > maxc) ? maxc : $countones(fa[k]);
                if (mode == 0) begin
                    e_pa[k] = na;
                    e_pb[k] = nb;
                    e_v[k]  = (pi >= 0);
                    if (pi >= 0) begin
                        e_ia[k] = pi;
                        e_ib[k] = pj;
                    end
                end else begin
                    if (startOfFrame) begin
                        e_pa[k] = fa[k];
                        e_pb[k] = fb[k];
                        e_v[k]  = (fa[k] != 4'd0);
                        if (fa[k] != 4'd0) begin
                            e_ia[k] = fpa[k];
                            e_ib[k] = fpb[k];
                        end
                    end else begin
                        e_pa[k] = 4'd0;
                        e_pb[k] = 8'd0;
                        e_v[k]  = 1'b0;
                    end
                    if (pva == 4'd0 && pi >= 0) begin
                        fpa[k] = pi;
                        fpb[k] = pj;
                    end
                end
                fa[k] = pva | ha;
                fb[k] = pvb | hb;
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("pulse_a", k, 32'(pa[k]), 32'(e_pa[k]));
            chk("pulse_b", k, 32'(pb[k]), 32'(e_pb[k]));
            chk("pair_valid", k, 32'(pv[k]), 32'(e_v[k]));
            chk("a_idx", k, 32'(ia[k]), 32'(e_ia[k]));
            chk("b_idx", k, 32'(ib[k]), 32'(e_ib[k]));
            chk("frame_count", k, 32'(cnt[k]), 32'(e_cnt[k]));
        end
    end

    task automatic cyc(input logic s, input logic e, input logic [3:0] av, input logic [7:0] bv);
        startOfFrame = s;
        enable = e;
        aReq = av;
        bReq = bv;
        @(negedge clk);
    endtask

    initial begin
        int gap;
        #1 resetN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_pulse_a", 0, 32'(pa[0]), 32'h0);
        chk("reset_valid", 1, 32'(pv[1]), 32'h0);
        chk("reset_count", 2, 32'(cnt[2]), 32'h0);
        resetN = 1'b1;

        // single overlap held for three cycles
        cyc(1'b1, 1'b1, 4'b0000, 8'h00);
        cyc(1'b0, 1'b1, 4'b0010, 8'h10);
        chk("lit_pa_first", 0, 32'(pa[0]), 32'h2);
        chk("lit_pb_first", 0, 32'(pb[0]), 32'h10);
        chk("lit_pair", 0, {pv[0], 8'(ia[0]), 8'(ib[0])}, {1'b1, 8'd1, 8'd4});
        chk("lit_m1_silent", 1, 32'(pa[1]), 32'h0);
        cyc(1'b0, 1'b1, 4'b0010, 8'h10);
        chk("lit_pa_once", 0, 32'(pa[0]), 32'h0);
        chk("lit_idx_hold", 0, 32'(ia[0]), 32'h1);
        cyc(1'b0, 1'b1, 4'b0010, 8'h10);
        cyc(1'b1, 1'b1, 4'b0000, 8'h00);
        chk("lit_cnt1", 0, 32'(cnt[0]), 32'h1);
        chk("lit_m1_pa", 1, 32'(pa[1]), 32'h2);
        chk("lit_m1_pair", 1, {pv[1], 8'(ia[1]), 8'(ib[1])}, {1'b1, 8'd1, 8'd4});

        // two A channels and two B channels together
        cyc(1'b0, 1'b1, 4'b1010, 8'h03);
        chk("lit_pa_multi", 0, 32'(pa[0]), 32'ha);
        chk("lit_pb_multi", 0, 32'(pb[0]), 32'h03);
        chk("lit_pair_multi", 0, {8'(ia[0]), 8'(ib[0])}, {8'd1, 8'd0});
        cyc(1'b1, 1'b1, 4'b0000, 8'h00);
        chk("lit_cnt2", 0, 32'(cnt[0]), 32'h2);
        chk("lit_m1_pa_multi", 1, 32'(pa[1]), 32'ha);

        // overlap on the frame-boundary cycle belongs to the new frame
        cyc(1'b0, 1'b1, 4'b0010, 8'h01);
        chk("lit_pre_sof", 0, 32'(pa[0]), 32'h2);
        cyc(1'b1, 1'b1, 4'b0010, 8'h01);
        chk("lit_sof_hit", 0, 32'(pa[0]), 32'h2);
        chk("lit_m1_sof_prev", 1, 32'(pa[1]), 32'h2);
        cyc(1'b0, 1'b1, 4'b0010, 8'h01);
        chk("lit_sof_flagged", 0, 32'(pa[0]), 32'h0);
        cyc(1'b1, 1'b1, 4'b0000, 8'h00);
        chk("lit_sof_cnt", 0, 32'(cnt[0]), 32'h1);

        // deferred mode: A0 then A3
        cyc(1'b0, 1'b1, 4'b0001, 8'h20);
        chk("lit_m1_quiet", 1, 32'(pa[1]), 32'h0);
        cyc(1'b0, 1'b1, 4'b1000, 8'h04);
        cyc(1'b1, 1'b1, 4'b0000, 8'h00);
        chk("lit_m1_1001", 1, 32'(pa[1]), 32'h9);
        chk("lit_m1_pb", 1, 32'(pb[1]), 32'h24);
        chk("lit_m1_pair05", 1, {pv[1], 8'(ia[1]), 8'(ib[1])}, {1'b1, 8'd0, 8'd5});
        chk("lit_m1_cnt", 1, 32'(cnt[1]), 32'h2);
        cyc(1'b0, 1'b1, 4'b0000, 8'h00);
        chk("lit_m1_one_cycle", 1, 32'(pa[1]), 32'h0);

        // saturation on the narrow counter
        cyc(1'b0, 1'b1, 4'b1111, 8'h01);
        chk("lit_all_a", 2, 32'(pa[2]), 32'hf);
        cyc(1'b1, 1'b1, 4'b0000, 8'h00);
        chk("lit_sat", 2, 32'(cnt[2]), 32'h3);
        chk("lit_nosat", 0, 32'(cnt[0]), 32'h4);

        // disabled with continuous overlap
        for (int n = 0; n < 4; n++) cyc(1'b0, 1'b0, 4'hf, 8'hff);
        chk("lit_dis_pa", 0, 32'(pa[0]), 32'h0);
        chk("lit_dis_v", 0, 32'(pv[0]), 32'h0);
        cyc(1'b1, 1'b0, 4'hf, 8'hff);
        chk("lit_dis_cnt", 0, 32'(cnt[0]), 32'h0);
        chk("lit_dis_m1", 1, 32'(pa[1]), 32'h0);

        // reset in the middle of a deferred frame
        cyc(1'b0, 1'b1, 4'b0100, 8'h80);
        resetN = 1'b0;
        cyc(1'b0, 1'b0, 4'b0000, 8'h00);
        chk("lit_rst_ib", 1, 32'(ib[1]), 32'h0);
        chk("lit_rst_cnt", 1, 32'(cnt[1]), 32'h0);
        resetN = 1'b1;
        cyc(1'b0, 1'b1, 4'b0000, 8'h00);
        cyc(1'b1, 1'b1, 4'b0000, 8'h00);
        chk("lit_rst_no_pulse", 1, 32'(pa[1]), 32'h0);
        chk("lit_rst_no_pair", 1, 32'(pv[1]), 32'h0);

        // randomized frames, sparse requests, occasional disables and resets
        gap = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 350) begin
                resetN = 1'b0;
                cyc(1'b0, 1'b0, 4'b0000, 8'h00);
                cyc(1'b0, 1'b0, 4'b0000, 8'h00);
                resetN = 1'b1;
            end
            if (gap == 0) begin
                gap = $urandom_range(30, 4);
                cyc(1'b1, ($urandom_range(9, 0) != 0), 4'($urandom & $urandom),
                    8'($urandom & $urandom & $urandom));
            end else begin
                gap--;
                cyc(1'b0, ($urandom_range(9, 0) != 0), 4'($urandom & $urandom),
                    8'($urandom & $urandom & $urandom));
            end
        end

        cyc(1'b0, 1'b0, 4'b0000, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/collision_matrix.md
Name: collision_matrix

Overview:
- Parametrised successor to the fixed-size pairwise collision detectors (player/tree, bird/shot, player/shit). Compares N_A "group A" drawing-request lines against N_B "group B" lines on every pixel clock.
- Produces at most one hit pulse per channel per frame, in either immediate or frame-deferred mode.
- Also reports the lowest-index colliding pair and a saturating per-frame hit count.
- Sits between the object TOP blocks' bus-request outputs and the game controller / object TOPs that consume SingleHitPulse.

Parameters:
- N_A, 4, number of group-A channels (1..16)
- N_B, 8, number of group-B channels (1..16)
- MODE, 0, 0 = immediate pulse on first overlapping pixel; 1 = deferred, pulses for the previous frame issued on the cycle after startOfFrame
- CNT_W, 4, width of frame_hit_count (saturating)

Ports:
- clk  in  1  system clock (50 MHz)
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle frame-boundary strobe from VGA controller
- enable  in  1  detection enable; when 0 no new hits are recorded
- aDrawingRequest  in  N_A  per-channel group-A drawing requests for the current pixel
- bDrawingRequest  in  N_B  per-channel group-B drawing requests for the current pixel
- SingleHitPulse_a  out  N_A  one-cycle hit pulse per A channel
- SingleHitPulse_b  out  N_B  one-cycle hit pulse per B channel
- hit_pair_valid  out  1  one-cycle strobe: hit_a_idx/hit_b_idx valid
- hit_a_idx  out  $clog2(N_A) (min 1)  index of reported A channel
- hit_b_idx  out  $clog2(N_B) (min 1)  index of reported B channel
- frame_hit_count  out  CNT_W  number of distinct A channels hit in the last completed frame

Behaviour:
- Reset (resetN=0, async): all outputs, flags_a, flags_b, pair registers and counters = 0.
- Overlap: ov[i][j] = aDrawingRequest[i] & bDrawingRequest[j].
  - hitA[i] = OR over j of ov[i][j].
  - hitB[j] = OR over i of ov[i][j].
  - Both are gated by enable.
- Frame flags:
  - flags_a/flags_b record channels already hit in the current frame.
  - On startOfFrame, flags clear. Any overlap on the same cycle counts for the NEW frame, so the flag is set after the clear.
- newA = hitA & ~flags_a (with flags taken as 0 on a startOfFrame cycle); newB likewise.
- MODE 0:
  - SingleHitPulse_a <= newA and SingleHitPulse_b <= newB, registered, 1-cycle latency.
  - Each channel pulses at most once per frame.
  - Multiple channels may pulse on the same cycle.
- MODE 1:
  - Flags accumulate silently.
  - On the cycle after startOfFrame, SingleHitPulse_a/_b = flags of the just-finished frame for exactly one cycle; otherwise 0.
  - Overlap during the startOfFrame cycle belongs to the new frame and is not included.
- Pair report:
  - pi = lowest i in newA; pj = lowest j with ov[pi][j].
  - MODE 0: hit_pair_valid pulses with the A pulses whenever newA≠0; indices = (pi,pj).
  - MODE 1: the first pair of the frame is stored; hit_pair_valid and indices are issued alongside the deferred pulses, only if the frame had ≥1 hit.
  - Indices hold their value between strobes.
- A new B hit whose A channel is already flagged produces a B pulse but no pair strobe.
- Counter:
  - A running count increments by popcount(newA) per cycle and saturates at 2^CNT_W−1.
  - On startOfFrame, frame_hit_count <= running count (including any same-cycle increments belonging to the old frame: none, by the rule above); the running count then restarts at popcount(newA) of that cycle.
- enable=0: flags, pair registers and running count hold; no pulses in MODE 0. In MODE 1 the deferred pulse still reflects flags already recorded.
- Reset mid-frame discards all flags. The first frame after reset emits no MODE 1 pulses until its following startOfFrame.

Test Plan:
- MODE 0, N_A=4, N_B=8: a=0010, b=00010000 for 3 cycles → SingleHitPulse_a=0010 and _b=00010000 for exactly 1 cycle, 1 cycle after the first overlap; hit_pair_valid=1, idx=(1,4); no further pulses that frame.
- MODE 0: a=1010, b=00000011 same cycle → pulse_a=1010, pulse_b=00000011, pair=(1,0); after next startOfFrame, frame_hit_count=2.
- MODE 0: overlap on the startOfFrame cycle on a channel already hit in the prior frame → pulse fires 1 cycle later; flag set for the new frame.
- MODE 1: hits on A0 and A3 mid-frame → no pulses; cycle after startOfFrame, pulse_a=1001 for 1 cycle, pair=(0,first j), frame_hit_count=2.
- CNT_W=2: 4 A channels hit in one frame → frame_hit_count=3 (saturated).
- enable=0 with continuous overlap → no pulses, count 0; assert resetN low mid-frame in MODE 1 → all outputs 0 and no deferred pulse at the next startOfFrame.
